// File: rtl/joy_event_fifo.sv
// Joystick change-event queue. Each player's button word is sampled every
// cycle; a scan pointer walks the active players, and each cycle at most one
// changed button is reported as a press/release event. Events sit in a
// first-word-fall-through FIFO read through ev_rd.
module joy_event_fifo #(
  parameter int DEPTH   = 16,
  parameter int PLAYERS = 6
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [32*PLAYERS-1:0]   joystick,
  input  logic                    player_count,
  input  logic                    ev_rd,
  output logic [7:0]              ev_data,
  output logic                    ev_empty,
  output logic [$clog2(DEPTH):0]  ev_count,
  output logic                    ev_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  // Per-player sampled and last-reported button states, flattened for selection.
  logic [PLAYERS-1:0][15:0] w_cur;
  logic [PLAYERS-1:0][15:0] w_last;
  logic [16*PLAYERS-1:0]    w_unused_hi;

  // Scanner.
  logic [PW-1:0] r_ptr;
  logic [15:0]   w_sel_cur;
  logic [15:0]   w_sel_last;
  logic [15:0]   w_diff;
  logic [3:0]    w_bit;
  logic [3:0]    w_ptr4;
  logic          w_active;
  logic          w_change;
  logic          w_push;
  logic [7:0]    w_wdata;

  // Queue storage and bookkeeping.
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic [7:0]    r_head;
  logic          w_pop;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_count_next;

  generate
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [15:0] r_cur;
      logic [15:0] r_last;

      // Input stage: only the low half of each player word carries buttons.
      always_ff @(posedge clk_sys) begin
        if (reset) r_cur <= '0;
        else       r_cur <= joystick[32*gi +: 16];
      end

      // Record the reported state of the single bit pushed for this player.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          r_last <= '0;
        end else if (w_push && (r_ptr == PW'(gi))) begin
          r_last[w_bit] <= r_cur[w_bit];
        end
      end

      assign w_cur[gi]  = r_cur;
      assign w_last[gi] = r_last;
      assign w_unused_hi[16*gi +: 16] = joystick[32*gi+16 +: 16];
    end
  endgenerate

  assign w_sel_cur  = w_cur[r_ptr];
  assign w_sel_last = w_last[r_ptr];
  assign w_diff     = w_sel_cur ^ w_sel_last;

  // Lowest changed bit wins so several changes of one player emit in ascending order.
  always_comb begin
    w_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_diff[i]) w_bit = 4'(i);
    end
  end

  // Players 4 and up are never active; player_count picks 2 or 4 active players.
  assign w_ptr4   = 4'(r_ptr);
  assign w_active = player_count ? (w_ptr4 < 4'd4) : (w_ptr4 < 4'd2);
  assign w_change = w_active && (w_diff != 16'd0);
  // Gate on the full flag as it stood at the start of the cycle: a pop while
  // full does not make room for a push until the following cycle.
  assign w_push   = w_change && !r_full;
  assign w_wdata  = {w_sel_cur[w_bit], 3'(r_ptr), w_bit};

  // Advance past idle/inactive players; hold while a change is pending so
  // nothing is lost when the queue is full.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (!w_change) begin
      r_ptr <= (r_ptr == PW'(PLAYERS - 1)) ? '0 : r_ptr + PW'(1);
    end
  end

  assign w_pop        = ev_rd && !r_empty;
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Event storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_full   <= (w_count_next == CW'(DEPTH));
    end
  end

  // Head register read from the next read address; when the entry being
  // written becomes the head this cycle, take it straight from the write data.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_head <= 8'h00;
    end else if (w_push && (r_wr_ptr == w_rd_next)) begin
      r_head <= w_wdata;
    end else if (w_count_next != '0) begin
      r_head <= r_mem[w_rd_next];
    end
  end

  assign ev_data  = r_head;
  assign ev_empty = r_empty;
  assign ev_count = r_count;
  assign ev_full  = r_full;

endmodule

// File: tb/tb_joy_event_fifo.sv
// Bench for joy_event_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed event codes.
module tb_joy_event_fifo;
  localparam int DEPTH   = 16;
  localparam int PLAYERS = 6;

  logic                  clk_sys = 1'b0;
  logic                  reset = 1'b1;
  logic [32*PLAYERS-1:0] joystick = '0;
  logic                  player_count = 1'b0;
  logic                  ev_rd = 1'b0;
  logic [7:0]            ev_data;
  logic                  ev_empty;
  logic [4:0]            ev_count;
  logic                  ev_full;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  joy_event_fifo #(.DEPTH(DEPTH), .PLAYERS(PLAYERS)) dut (
    .clk_sys(clk_sys), .reset(reset), .joystick(joystick),
    .player_count(player_count), .ev_rd(ev_rd), .ev_data(ev_data),
    .ev_empty(ev_empty), .ev_count(ev_count), .ev_full(ev_full)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button state per player, last reported state, a scan position and a plain queue.
  logic [15:0] m_cur  [PLAYERS];
  logic [15:0] m_last [PLAYERS];
  int          m_ptr = 0;
  logic [7:0]  m_q[$];
  bit          m_valid = 0;
  bit          m_was_full;
  int          m_limit;
  int          m_b;
  logic [15:0] m_d;

  always @(posedge clk_sys) begin
    if (reset) begin
      for (int p = 0; p < PLAYERS; p++) begin
        m_cur[p]  = '0;
        m_last[p] = '0;
      end
      m_ptr = 0;
      m_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      m_was_full = (m_q.size() == DEPTH);
      m_limit = player_count ? 4 : 2;
      m_d = m_cur[m_ptr] ^ m_last[m_ptr];
      if (ev_rd && m_q.size() != 0) void'(m_q.pop_front());
      if (m_ptr < m_limit && m_d != 16'd0) begin
        if (!m_was_full) begin
          m_b = 0;
          for (int i = 15; i >= 0; i--) if (m_d[i]) m_b = i;
          m_q.push_back({m_cur[m_ptr][m_b], 3'(m_ptr), 4'(m_b)});
          m_last[m_ptr][m_b] = m_cur[m_ptr][m_b];
        end
      end else begin
        m_ptr = (m_ptr + 1) % PLAYERS;
      end
      for (int p = 0; p < PLAYERS; p++) m_cur[p] = joystick[32*p +: 16];
    end
  end

  // Every cycle: compare all outputs with the model, away from the active edge.
  always @(negedge clk_sys) begin
    if (m_valid) begin
      check("model_count", 32'(ev_count), 32'(m_q.size()));
      check("model_empty", 32'(ev_empty), 32'(m_q.size() == 0));
      check("model_full",  32'(ev_full),  32'(m_q.size() == DEPTH));
      if (m_q.size() != 0) check("model_data", 32'(ev_data), 32'(m_q[0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int k = 0;
    while (ev_count != 5'(target) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(ev_count), 32'(target));
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string name);
    check(name, 32'(ev_data), 32'(exp));
    ev_rd = 1'b1;
    tick(1);
    ev_rd = 1'b0;
  endtask

  task automatic drain(input int n);
    ev_rd = 1'b1;
    tick(n);
    ev_rd = 1'b0;
  endtask

  int seen [256];
  int total;
  logic [7:0] code;

  initial begin
    tick(3);
    reset = 1'b0;
    check("reset_count", 32'(ev_count), 32'd0);
    check("reset_empty", 32'(ev_empty), 32'd1);
    check("reset_full",  32'(ev_full),  32'd0);
    check("reset_data",  32'(ev_data),  32'h00);
    $display("txn reset: count=%0d empty=%0d", ev_count, ev_empty);

    // Player 0 bit 9 press and release.
    joystick[9] = 1'b1;
    wait_count(1, 12, "p0b9_press_count");
    $display("txn press p0 b9: data=%02h", ev_data);
    pop_expect(8'h89, "p0b9_press_data");
    joystick[9] = 1'b0;
    wait_count(1, 12, "p0b9_release_count");
    $display("txn release p0 b9: data=%02h", ev_data);
    pop_expect(8'h09, "p0b9_release_data");

    // Player 3 is inactive until player_count goes high.
    joystick[32*3 + 0] = 1'b1;
    tick(20);
    check("p3_inactive_count", 32'(ev_count), 32'd0);
    player_count = 1'b1;
    wait_count(1, 12, "p3_active_count");
    $display("txn press p3 b0: data=%02h", ev_data);
    pop_expect(8'hB0, "p3_active_data");

    // Three bits of player 1 in one cycle: ascending order, consecutive cycles.
    joystick[32*1 + 0] = 1'b1;
    joystick[32*1 + 2] = 1'b1;
    joystick[32*1 + 5] = 1'b1;
    wait_count(1, 12, "p1_multi_first");
    tick(2);
    check("p1_multi_count", 32'(ev_count), 32'd3);
    $display("txn p1 multi: count=%0d", ev_count);
    pop_expect(8'h90, "p1_multi_0");
    pop_expect(8'h92, "p1_multi_1");
    pop_expect(8'h95, "p1_multi_2");
    check("p1_multi_drained", 32'(ev_count), 32'd0);

    // 20 presses with no reads: fills, stalls, then all 20 come out once.
    joystick[32*2 +: 16] = 16'hFFFF;
    joystick[3:0] = 4'hF;
    tick(80);
    check("overflow_full",  32'(ev_full),  32'd1);
    check("overflow_count", 32'(ev_count), 32'd16);
    $display("txn overflow: count=%0d full=%0d", ev_count, ev_full);
    for (int i = 0; i < 256; i++) seen[i] = 0;
    total = 0;
    for (int c = 0; c < 100; c++) begin
      if (!ev_empty) begin
        seen[ev_data]++;
        total++;
        ev_rd = 1'b1;
      end else begin
        ev_rd = 1'b0;
      end
      tick(1);
    end
    ev_rd = 1'b0;
    check("overflow_total", 32'(total), 32'd20);
    for (int b = 0; b < 16; b++) begin
      code = 8'hA0 + 8'(b);
      check($sformatf("overflow_p2_b%0d", b), 32'(seen[code]), 32'd1);
    end
    for (int b = 0; b < 4; b++) begin
      code = 8'h80 + 8'(b);
      check($sformatf("overflow_p0_b%0d", b), 32'(seen[code]), 32'd1);
    end
    $display("txn overflow drain: popped=%0d", total);

    // Read on empty is ignored; simultaneous push and pop keeps the count.
    ev_rd = 1'b1;
    tick(1);
    ev_rd = 1'b0;
    check("rd_on_empty", 32'(ev_count), 32'd0);
    joystick[32*1 + 8 +: 6] = 6'h3F;
    wait_count(5, 20, "count_reach_5");
    ev_rd = 1'b1;
    tick(1);
    ev_rd = 1'b0;
    check("push_pop_count", 32'(ev_count), 32'd5);
    $display("txn push+pop at 5: count=%0d", ev_count);
    drain(10);
    check("push_pop_drained", 32'(ev_count), 32'd0);

    // Release everything and flush the release events.
    joystick = '0;
    drain(80);
    check("release_drained", 32'(ev_count), 32'd0);

    // Seven queued entries discarded by reset; held p0 bit 1 reappears.
    joystick[1] = 1'b1;
    joystick[32*1 +: 6] = 6'h3F;
    wait_count(7, 40, "pre_reset_count");
    reset = 1'b1;
    ev_rd = 1'b1;
    joystick = '0;
    joystick[1] = 1'b1;
    tick(1);
    check("in_reset_count", 32'(ev_count), 32'd0);
    check("in_reset_empty", 32'(ev_empty), 32'd1);
    check("in_reset_data",  32'(ev_data),  32'h00);
    tick(1);
    reset = 1'b0;
    ev_rd = 1'b0;
    wait_count(1, 20, "post_reset_count");
    check("post_reset_data", 32'(ev_data), 32'h81);
    $display("txn post-reset: data=%02h", ev_data);
    tick(20);
    check("post_reset_single", 32'(ev_count), 32'd1);
    drain(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/joy_event_fifo.md
JOY_EVENT_FIFO -- requirements
Module: joy_event_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; SHALL be a power of two, 4..64.
REQ-002 Parameter PLAYERS, default 6, meaning joystick words scanned.
REQ-003 clk_sys  input  1  the block's only clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 joystick  input  32*PLAYERS  packed player words, player 0 in [31:0]; only bits [15:0] of each word SHALL be used.
REQ-006 player_count  input  1  0 = players 0-1 active, 1 = players 0-3 active; players 4-5 are never active.
REQ-007 ev_rd  input  1  pop strobe for the head entry.
REQ-008 ev_data  output  8  head entry: [7] pressed(1)/released(0), [6:4] player, [3:0] bit index.
REQ-009 ev_empty  output  1  FIFO empty.
REQ-010 ev_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 ev_full  output  1  ev_count == DEPTH.

Function
REQ-012 joystick[15:0] of each player SHALL be registered into cur[p] every cycle (1-cycle input stage).
REQ-013 The block SHALL hold last[p][15:0] per player, the last reported state of each bit.
REQ-014 A scan pointer ptr (0..PLAYERS-1) SHALL evaluate diff = cur[ptr] ^ last[ptr] every cycle.
REQ-015 If ptr is an inactive player or diff == 0, ptr SHALL advance by one, wrapping PLAYERS-1 -> 0.
REQ-016 If diff != 0 and !ev_full, the block SHALL push {cur[ptr][i], ptr[2:0], i[3:0]}, i = lowest set bit of diff, and set last[ptr][i] <= cur[ptr][i]; ptr SHALL NOT advance that cycle.
REQ-017 If diff != 0 and ev_full, no push and no last update SHALL occur; ptr SHALL hold (stall), so no pending change is lost.
REQ-018 At most one event SHALL be pushed per cycle; multiple changed bits of one player SHALL emit in ascending bit order on consecutive cycles.
REQ-019 A press then release both completed while stalled SHALL produce no event (state comparison only); this is intended.
REQ-020 Latency: with ptr at player p when cur[p] changes, the push SHALL occur on the next edge; ev_empty SHALL fall 2 cycles after the joystick change.
REQ-021 FIFO SHALL be first-word-fall-through: ev_data valid whenever !ev_empty, updating on the edge after a pop.
REQ-022 ev_rd while ev_empty SHALL be ignored (no pointer or count change).
REQ-023 Push gating SHALL use ev_full at cycle start; simultaneous pop when full SHALL pop only, with the push deferred one cycle.
REQ-024 Simultaneous push and pop when not full and not empty SHALL leave ev_count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; ev_count SHALL never exceed DEPTH nor underflow.
REQ-026 Changing player_count SHALL only affect subsequent scans; last[] of newly inactive players SHALL be retained.

Reset
REQ-027 On reset: ev_count = 0, ev_empty = 1, ev_full = 0, FIFO pointers = 0, ptr = 0, cur[] = 0, last[] = 0; ev_data SHALL read 8'h00.
REQ-028 Reset SHALL take priority over ev_rd and any push in the same cycle; entries queued before reset SHALL be discarded.
REQ-029 Buttons held through reset SHALL generate press events after reset deasserts (last[] cleared to 0).

Verification
REQ-030 Reset, then player 0 bit 9 asserted -> single entry 8'h89 within 2 cycles; release -> entry 8'h09.
REQ-031 player_count=0, player 3 bit 0 pressed -> no event; set player_count=1 -> event 8'hB0.
REQ-032 Player 1 bits 0,2,5 asserted same cycle -> entries 8'h90, 8'h92, 8'h95 on consecutive cycles in that order.
REQ-033 DEPTH=16, 20 distinct presses, no reads -> ev_full=1, ev_count=16; pop all -> remaining 4 emitted, none lost or duplicated.
REQ-034 ev_rd on empty FIFO -> ev_count stays 0; ev_rd with push when count=5 -> count stays 5.
REQ-035 Reset asserted with ev_count=7 and player 0 bit 1 held -> ev_count=0 at reset; after deassert one entry 8'h81.
